// File: rtl/cmd_fifo_if.sv
// Valid/ready command handshakes around cmd_fifo: processor write side and converter read side.
// The master modport is the environment (processor + converter); the slave modport is the FIFO.
interface cmd_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_cmd_valid;
  logic                  cpu_cmd_ready;
  logic [DATA_WIDTH-1:0] cpu_cmd_wdata;
  logic                  fifo_cmd_valid;
  logic                  fifo_cmd_ready;
  logic [DATA_WIDTH-1:0] fifo_cmd_wdata;

  modport master (
    output cpu_cmd_valid, cpu_cmd_wdata, fifo_cmd_ready,
    input  cpu_cmd_ready, fifo_cmd_valid, fifo_cmd_wdata
  );

  modport slave (
    input  cpu_cmd_valid, cpu_cmd_wdata, fifo_cmd_ready,
    output cpu_cmd_ready, fifo_cmd_valid, fifo_cmd_wdata
  );
endinterface

// File: rtl/cmd_fifo.sv
// First-word-fall-through command FIFO between the processor command port and dwc_cmd.
// Full/empty come only from the registered occupancy count; sticky flags catch protocol abuse.
module cmd_fifo #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 8,
  parameter  int AFULL_THRESH = DEPTH - 2,
  localparam int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  cmd_fifo_if.slave            bus,
  output logic [CNT_WIDTH-1:0] cmd_count,
  output logic                 cmd_afull,
  output logic                 cmd_overflow,
  output logic                 cmd_underflow
);

  localparam int                   PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AFULL_CNT = CNT_WIDTH'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [CNT_WIDTH-1:0]  count_next;

  assign full  = (cmd_count == FULL_CNT);
  assign empty = (cmd_count == '0);

  // Ready ignores the read side, so a full FIFO never writes through.
  assign bus.cpu_cmd_ready  = !full;
  assign bus.fifo_cmd_valid = !empty;
  assign bus.fifo_cmd_wdata = empty ? '0 : mem[rd_ptr];

  assign push = bus.cpu_cmd_valid && !full;
  assign pop  = bus.fifo_cmd_ready && !empty;

  always_comb begin
    count_next = cmd_count;
    if (push && !pop) begin
      count_next = cmd_count + CNT_WIDTH'(1);
    end else if (pop && !push) begin
      count_next = cmd_count - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= bus.cpu_cmd_wdata;
    end
  end

  // Sticky flags look at the pre-edge count and survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cmd_count     <= '0;
      cmd_afull     <= 1'b0;
      cmd_overflow  <= 1'b0;
      cmd_underflow <= 1'b0;
    end else begin
      if (bus.cpu_cmd_valid && full) begin
        cmd_overflow <= 1'b1;
      end
      if (bus.fifo_cmd_ready && empty) begin
        cmd_underflow <= 1'b1;
      end
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        cmd_count <= '0;
        cmd_afull <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_WIDTH'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        end
        cmd_count <= count_next;
        cmd_afull <= (count_next >= AFULL_CNT);
      end
    end
  end

endmodule

// File: tb/tb_cmd_fifo.sv
// Self-checking bench for cmd_fifo (DEPTH=4, AFULL_THRESH=2): vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_cmd_fifo;

  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int THRESH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] cmd_count;
  logic       cmd_afull;
  logic       cmd_overflow;
  logic       cmd_underflow;

  cmd_fifo_if #(.DATA_WIDTH(DW)) bus ();

  cmd_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(THRESH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .cmd_count    (cmd_count),
    .cmd_afull    (cmd_afull),
    .cmd_overflow (cmd_overflow),
    .cmd_underflow(cmd_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [31:0] wdata;
    logic        ready;
    int          exp_count;
    logic        exp_valid;
    logic [31:0] exp_wdata;
    logic        exp_ready;
    logic        exp_afull;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs [11];

  // Reference model: plain queue plus sticky flags.
  logic [31:0] mq [$];
  logic        m_ovf;
  logic        m_unf;

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(logic r, logic f, logic v, logic [31:0] d, logic rd);
    @(negedge clk);
    rst                = r;
    flush              = f;
    bus.cpu_cmd_valid  = v;
    bus.cpu_cmd_wdata  = d;
    bus.fifo_cmd_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(string tag, int cnt, logic v, logic [31:0] d, logic rdy,
                          logic af, logic ov, logic un);
    checkOutput({tag, " count"},     32'(cmd_count),          32'(cnt));
    checkOutput({tag, " valid"},     32'(bus.fifo_cmd_valid), 32'(v));
    checkOutput({tag, " wdata"},     bus.fifo_cmd_wdata,      d);
    checkOutput({tag, " ready"},     32'(bus.cpu_cmd_ready),  32'(rdy));
    checkOutput({tag, " afull"},     32'(cmd_afull),          32'(af));
    checkOutput({tag, " overflow"},  32'(cmd_overflow),       32'(ov));
    checkOutput({tag, " underflow"}, 32'(cmd_underflow),      32'(un));
  endtask

  task automatic modelStep(logic r, logic f, logic v, logic [31:0] d, logic rd);
    int size;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      size = mq.size();
      if (v && size == DEPTH) m_ovf = 1'b1;
      if (rd && size == 0) m_unf = 1'b1;
      if (f) begin
        mq.delete();
      end else begin
        if (rd && size > 0) void'(mq.pop_front());
        if (v && size < DEPTH) mq.push_back(d);
      end
    end
  endtask

  function automatic logic [31:0] wordOf(logic [7:0] tag, int i);
    return {tag, 16'h0000, 8'(i)};
  endfunction

  initial begin
    logic [31:0] seq [12];
    logic [31:0] words [4];
    int          idx;
    int          sz;
    logic        r, f, v, rd;
    logic [31:0] d;

    rst                = 1'b1;
    flush              = 1'b0;
    bus.cpu_cmd_valid  = 1'b0;
    bus.cpu_cmd_wdata  = '0;
    bus.fifo_cmd_ready = 1'b0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkAll("reset", 0, 0, 0, 1, 0, 0, 0);

    // Fill, overflow attempts, drain, extra ready for underflow.
    vecs[0]  = '{1'b0, 1'b1, wordOf(8'hA0, 0), 1'b0, 1, 1'b1, wordOf(8'hA0, 0), 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, wordOf(8'hA0, 1), 1'b0, 2, 1'b1, wordOf(8'hA0, 0), 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, wordOf(8'hA0, 2), 1'b0, 3, 1'b1, wordOf(8'hA0, 0), 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, wordOf(8'hA0, 3), 1'b0, 4, 1'b1, wordOf(8'hA0, 0), 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, wordOf(8'hA0, 4), 1'b0, 4, 1'b1, wordOf(8'hA0, 0), 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, wordOf(8'hA0, 4), 1'b0, 4, 1'b1, wordOf(8'hA0, 0), 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,            1'b1, 3, 1'b1, wordOf(8'hA0, 1), 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,            1'b1, 2, 1'b1, wordOf(8'hA0, 2), 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,            1'b1, 1, 1'b1, wordOf(8'hA0, 3), 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,            1'b1, 0, 1'b0, 32'h0,            1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,            1'b1, 0, 1'b0, 32'h0,            1'b1, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(0, vecs[i].flush, vecs[i].valid, vecs[i].wdata, vecs[i].ready);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid, vecs[i].exp_wdata,
               vecs[i].exp_ready, vecs[i].exp_afull, vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    // Steady-state push+pop at count 2 across pointer wrap.
    seq[0] = wordOf(8'hE1, 0);
    seq[1] = wordOf(8'hE1, 1);
    for (int k = 0; k < 10; k++) seq[k + 2] = wordOf(8'hB0, k);
    applyStimulus(0, 0, 1, seq[0], 0);
    applyStimulus(0, 0, 1, seq[1], 0);
    checkOutput("pp prefill count", 32'(cmd_count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("pp pop%0d", k), bus.fifo_cmd_wdata, seq[k]);
      applyStimulus(0, 0, 1, wordOf(8'hB0, k), 1);
      checkOutput($sformatf("pp count%0d", k), 32'(cmd_count), 32'd2);
    end
    checkOutput("pp final head", bus.fifo_cmd_wdata, seq[10]);

    // Flush beats a simultaneous push; next push falls through one cycle later.
    applyStimulus(0, 0, 1, wordOf(8'hE2, 0), 0);
    checkOutput("pre-flush count", 32'(cmd_count), 32'd3);
    applyStimulus(0, 1, 1, wordOf(8'hC0, 0), 0);
    checkAll("flush", 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 1, wordOf(8'hD0, 0), 0);
    checkAll("post-flush", 1, 1, wordOf(8'hD0, 0), 1, 0, 1, 1);

    // Converter-style alternating ready against four queued words.
    words[0] = wordOf(8'hD0, 0);
    for (int k = 1; k < 4; k++) begin
      words[k] = wordOf(8'hF0, k);
      applyStimulus(0, 0, 1, words[k], 0);
    end
    checkOutput("alt fill count", 32'(cmd_count), 32'd4);
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      rd = logic'(k % 2);
      applyStimulus(0, 0, 0, 0, rd);
      if (rd) idx++;
      checkOutput($sformatf("alt count%0d", k), 32'(cmd_count), 32'(4 - idx));
      if (idx < 4) checkOutput($sformatf("alt head%0d", k), bus.fifo_cmd_wdata, words[idx]);
    end

    // Random traffic against the queue model, with a reset in the middle.
    applyStimulus(1, 0, 0, 0, 0);
    modelStep(1, 0, 0, 0, 0);
    checkAll("rand reset", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r  = (i == 200);
      f  = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 80 : 35));
      rd = ($urandom_range(0, 99) < ((i % 100) < 50 ? 35 : 80));
      d  = $urandom;
      modelStep(r, f, v, d, rd);
      applyStimulus(r, f, v, d, rd);
      sz = mq.size();
      checkAll($sformatf("rand%0d", i), sz, sz > 0, (sz > 0) ? mq[0] : 32'h0,
               sz < DEPTH, sz >= THRESH, m_ovf, m_unf);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
